// File: rtl/seq_generator_1010_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_generator_1010_if
//  Description : Control/status bundle for the serial pattern transmitter.
//  Revision    : 1.0
// ============================================================================
interface seq_generator_1010_if;
    logic       start;
    logic [7:0] repeat_cnt;
    logic [3:0] gap;
    logic       abort;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;

    modport master (
        output start, repeat_cnt, gap, abort,
        input  x, x_valid, busy, done
    );

    modport slave (
        input  start, repeat_cnt, gap, abort,
        output x, x_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/seq_generator_1010.sv
`default_nettype none
// ============================================================================
//  Module      : seq_generator_1010
//  Description : Emits PATTERN MSB-first, repeated with a programmable gap.
//  Revision    : 1.0
// ============================================================================
module seq_generator_1010 #(
    parameter int               PAT_W    = 4,
    parameter logic [PAT_W-1:0] PATTERN  = 4'b1010,
    parameter logic             IDLE_LVL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    seq_generator_1010_if.slave bus
);
    localparam int               IDX_W    = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q,    state_d;
    logic [3:0]       gap_q,      gap_d;
    logic [IDX_W-1:0] bit_idx_q,  bit_idx_d;
    logic [7:0]       rep_left_q, rep_left_d;
    logic [3:0]       gap_left_q, gap_left_d;
    logic             x_q,        x_d;
    logic             x_valid_q,  x_valid_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        bit_idx_d  = bit_idx_q;
        rep_left_d = rep_left_q;
        gap_left_d = gap_left_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    gap_d = bus.gap;
                    if (bus.repeat_cnt == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_SEND;
                        bit_idx_d  = LAST_IDX;
                        rep_left_d = bus.repeat_cnt;
                    end
                end
            end
            S_SEND: begin
                if (bit_idx_q == '0) begin
                    rep_left_d = rep_left_q - 8'd1;
                    bit_idx_d  = LAST_IDX;
                    if (rep_left_q == 8'd1) begin
                        state_d = S_DONE;
                    end else if (gap_q == 4'd0) begin
                        state_d = S_SEND;
                    end else begin
                        state_d    = S_GAP;
                        gap_left_d = gap_q;
                    end
                end else begin
                    bit_idx_d = bit_idx_q - IDX_W'(1);
                end
            end
            S_GAP: begin
                // gap_left counts the current gap cycle, so 1 means last one
                if (gap_left_q <= 4'd1) begin
                    state_d    = S_SEND;
                    bit_idx_d  = LAST_IDX;
                    gap_left_d = 4'd0;
                end else begin
                    gap_left_d = gap_left_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_q != S_IDLE) && bus.abort) begin
            state_d    = S_IDLE;
            bit_idx_d  = '0;
            rep_left_d = 8'd0;
            gap_left_d = 4'd0;
        end

        // Outputs are registered views of the state being entered
        x_d       = (state_d == S_SEND) ? PATTERN[bit_idx_d] : IDLE_LVL;
        x_valid_d = (state_d == S_SEND);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gap_q      <= 4'd0;
            bit_idx_q  <= '0;
            rep_left_q <= 8'd0;
            gap_left_q <= 4'd0;
            x_q        <= IDLE_LVL;
            x_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            bit_idx_q  <= bit_idx_d;
            rep_left_q <= rep_left_d;
            gap_left_q <= gap_left_d;
            x_q        <= x_d;
            x_valid_q  <= x_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.x       = x_q;
    assign bus.x_valid = x_valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_generator_1010.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_generator_1010
//  Description : Scoreboard bench for seq_generator_1010 (directed runs).
//  Revision    : 1.0
// ============================================================================
module tb_seq_generator_1010;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    // Each entry is one expected busy cycle: {x_valid, x, done}
    logic [2:0] sb[$];

    seq_generator_1010_if bus ();

    seq_generator_1010 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic push_lit(input int n, input logic [31:0] v, input logic [31:0] xs,
                            input logic [31:0] d);
        for (int i = n - 1; i >= 0; i--) sb.push_back({v[i], xs[i], d[i]});
    endtask

    task automatic check_outputs_idle(input string name);
        check({name, "_x"},       {31'd0, bus.x},       32'd0);
        check({name, "_x_valid"}, {31'd0, bus.x_valid}, 32'd0);
        check({name, "_busy"},    {31'd0, bus.busy},    32'd0);
        check({name, "_done"},    {31'd0, bus.done},    32'd0);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            if (!bus.busy) break;
        end
        check({name, "_finished"}, {31'd0, bus.busy}, 32'd0);
        check({name, "_sb_empty"}, sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic run_lit(input string name, input logic [7:0] r, input logic [3:0] g,
                           input int n, input logic [31:0] v, input logic [31:0] xs,
                           input logic [31:0] d);
        push_lit(n, v, xs, d);
        bus.repeat_cnt = r;
        bus.gap        = g;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.repeat_cnt = ~r;
        bus.gap        = ~g;
        wait_idle(name);
        @(posedge clk); #1;
    endtask

    // Monitor: every busy cycle must match the head of the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.busy) begin
                    if (sb.size() == 0) begin
                        check("mon_unexpected_busy", {29'd0, bus.x_valid, bus.x, bus.done}, 32'd0);
                    end else begin
                        check("mon_cycle", {29'd0, bus.x_valid, bus.x, bus.done},
                              {29'd0, sb.pop_front()});
                    end
                end else begin
                    check("mon_idle", {30'd0, bus.x_valid, bus.done}, 32'd0);
                end
            end
        end
    end

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.repeat_cnt = 8'd0;
        bus.gap        = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_idle("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset asserted during the second bit of an R=3 run
        push_lit(1, 32'b1, 32'b1, 32'b0);
        bus.repeat_cnt = 8'd3;
        bus.gap        = 4'd0;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_outputs_idle("async_rst");
        @(negedge clk); #1;
        rst = 1'b0;
        check("rst_sb_empty", sb.size(), 32'd0);
        sb.delete();
        @(posedge clk); #1;

        run_lit("r3g0", 8'd3, 4'd0, 13, 32'b1111111111110, 32'b1010101010100,
                32'b0000000000001);
        run_lit("r1g5", 8'd1, 4'd5, 5, 32'b11110, 32'b10100, 32'b00001);
        run_lit("r2g2", 8'd2, 4'd2, 11, 32'b11110011110, 32'b10100010100,
                32'b00000000001);
        run_lit("r0", 8'd0, 4'd3, 1, 32'b0, 32'b0, 32'b1);

        // start held high: accepted at edges N, N+2, N+4 only
        push_lit(3, 32'b000, 32'b000, 32'b111);
        bus.repeat_cnt = 8'd0;
        bus.start      = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle("held_start");
        @(posedge clk); #1;

        // abort in the 6th active cycle of R=4, G=1
        push_lit(6, 32'b111101, 32'b101001, 32'b000000);
        bus.repeat_cnt = 8'd4;
        bus.gap        = 4'd1;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check_outputs_idle("abort");
        check("abort_sb_empty", sb.size(), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        check("abort_no_done", {31'd0, bus.done}, 32'd0);

        // abort together with start in IDLE
        bus.repeat_cnt = 8'd2;
        bus.start      = 1'b1;
        bus.abort      = 1'b1;
        @(posedge clk); #1;
        check("abort_start_busy", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(posedge clk); #1;
        check("abort_start_busy2", {31'd0, bus.busy}, 32'd0);

        // fresh run after all of the above
        run_lit("final_r1g0", 8'd1, 4'd0, 5, 32'b11110, 32'b10100, 32'b00001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
